// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//
// Byte-serial 8N1 UART transmitter (LSB first) with a small input FIFO.
// Bytes are enqueued through a valid/ready write port. A four-state FSM
// (IDLE/START/DATA/STOP) pops the FIFO head and shifts it out at DIV clocks
// per bit. When more data is queued, frames are sent back to back with no
// idle gap.
//
// Parameters
//   DIV    clock cycles per serial bit (2..65535)
//   DEPTH  FIFO entries, power of two (2..16)
//
// Ports
//   clock        single clock for all state
//   reset        asynchronous, active-high; clears all state
//   io_wr_data   byte to enqueue
//   io_wr_valid  enqueue request, qualified by io_wr_ready
//   io_wr_ready  FIFO not full (depends only on current occupancy)
//   io_clr_ovf   synchronous clear of io_overflow
//   io_txd       registered serial line, idles high
//   io_busy      registered, high while a frame is on the line
//   io_level     FIFO occupancy, 0..DEPTH
//   io_overflow  sticky; set when a write is dropped because the FIFO is full
// -----------------------------------------------------------------------------
module uart_tx_core #(
  parameter int DIV   = 434,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               io_wr_data,
  input  logic                     io_wr_valid,
  output logic                     io_wr_ready,
  input  logic                     io_clr_ovf,
  output logic                     io_txd,
  output logic                     io_busy,
  output logic [$clog2(DEPTH):0]   io_level,
  output logic                     io_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q,   state_d;
  logic [CW-1:0]   baud_q,    baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q,   shift_d;
  logic            txd_q,     txd_d;
  logic            busy_q,    busy_d;
  logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0]   level_q,   level_d;
  logic            ovf_q,     ovf_d;

  logic [7:0]      mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Write-side handshake
  // ---------------------------------------------------------------------------
  logic wr_ready;
  logic push;
  logic drop;
  logic pop;
  logic fifo_nonempty;
  logic baud_done;
  logic [7:0] fifo_head;

  always_comb begin
    // Ready looks only at the registered occupancy, so a pop on this edge
    // never makes room for a push on the same edge.
    wr_ready      = (level_q != LEVEL_FULL);
    push          = io_wr_valid & wr_ready;
    drop          = io_wr_valid & ~wr_ready;
    fifo_nonempty = (level_q != '0);
    baud_done     = (baud_q == '0);
    fifo_head     = mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state, baud counter, shifter and pop request
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          baud_d    = BAUD_RELOAD;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      ST_STOP: begin
        if (baud_done) begin
          if (fifo_nonempty) begin
            // Chain straight into the next start bit, no idle cycle.
            pop       = 1'b1;
            shift_d   = fifo_head;
            baud_d    = BAUD_RELOAD;
            bit_idx_d = '0;
            state_d   = ST_START;
          end else begin
            baud_d  = '0;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line outputs. They are registered from the current state, so the line
  // trails the FSM by one clock: the start bit appears on the edge after the
  // pop, and each bit still lasts exactly DIV cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q != ST_IDLE);
    unique case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and overflow flag
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (io_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage. The head is read combinationally so a byte written on one
  // edge can be popped on the very next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= io_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_wr_ready = wr_ready;
  assign io_txd      = txd_q;
  assign io_busy     = busy_q;
  assign io_level    = level_q;
  assign io_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
// Testbench for uart_tx_core (DIV=4, DEPTH=4).
// A waveform-level model expands every popped byte into its 10*DIV expected
// line samples. A per-cycle compare process checks all outputs against the
// model, a serial decoder reassembles frames, and directed sequences add
// hand-computed literal expectations.
module tb_uart_tx_core;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          wr_ready;
  logic          txd;
  logic          busy;
  logic [LW-1:0] level;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_core #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clock      (clk),
    .reset      (rst),
    .io_wr_data (wr_data),
    .io_wr_valid(wr_valid),
    .io_wr_ready(wr_ready),
    .io_clr_ovf (clr_ovf),
    .io_txd     (txd),
    .io_busy    (busy),
    .io_level   (level),
    .io_overflow(overflow)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: FIFO as a queue of bytes, line as a queue of future txd samples.
  // A byte leaves the FIFO on an edge where the line has nothing left to send
  // for the following cycle; its frame then occupies the next 10*DIV cycles.
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  bit         wave[$];
  logic       m_txd  = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;

  initial begin : model
    bit         can_push;
    bit         do_pop;
    bit         v;
    logic [7:0] b;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        wave.delete();
        m_txd  = 1'b1;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
      end else begin
        cyc++;
        can_push = (mq.size() < DEPTH);
        if (wave.size() > 0) begin
          m_txd  = wave.pop_front();
          m_busy = 1'b1;
        end else begin
          m_txd  = 1'b1;
          m_busy = 1'b0;
        end
        do_pop = (mq.size() > 0) && (wave.size() == 0);
        if (do_pop) begin
          b = mq.pop_front();
          for (int p = 0; p < 10; p++) begin
            v = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
            for (int r = 0; r < DIV; r++) wave.push_back(v);
          end
        end
        if (wr_valid && can_push) mq.push_back(wr_data);
        if (wr_valid && !can_push) m_ovf = 1'b1;
        else if (clr_ovf)          m_ovf = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cyc_txd",      txd,      m_txd);
        check("cyc_busy",     busy,     m_busy);
        check("cyc_level",    level,    mq.size());
        check("cyc_wr_ready", wr_ready, (mq.size() < DEPTH));
        check("cyc_overflow", overflow, m_ovf);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serial decoder: samples mid-bit, records frame start cycles.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];

  initial begin : rx
    bit         active;
    int         cnt;
    logic [7:0] sh;
    active = 1'b0;
    cnt    = 0;
    sh     = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (txd == 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          rx_start.push_back(cyc);
        end
      end else begin
        cnt++;
        if ((cnt % DIV) == DIV / 2 && (cnt / DIV) >= 1 && (cnt / DIV) <= 8)
          sh[(cnt / DIV) - 1] = txd;
        if (cnt == 9 * DIV + DIV / 2) begin
          check("rx_stop_bit", txd, 1);
          rx_q.push_back(sh);
          $display("[TB] rx byte 0x%02h at edge %0d", sh, cyc);
          active = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int run = 0;
    for (int i = 0; i < maxc && run < 3; i++) begin
      step();
      if (!busy && level == 0) run++;
      else run = 0;
    end
    check("idle_timeout", (run >= 3), 1);
  endtask

  task automatic check_rx(input string name);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  // Hand-computed line levels per bit period for 0xA5: start, LSB..MSB, stop.
  int t1_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin : stim
    int k;
    int n;
    int idx;

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) step();
    check("rst_txd",   txd,      1);
    check("rst_busy",  busy,     0);
    check("rst_level", level,    0);
    check("rst_ovf",   overflow, 0);
    check("rst_ready", wr_ready, 1);
    rst = 1'b0;
    repeat (2) step();

    // ---- single byte 0xA5 ----
    rx_q.delete(); rx_start.delete();
    wr_data = 8'hA5; wr_valid = 1'b1; step(); k = cyc; wr_valid = 1'b0;
    $display("[TB] push 0xA5 accepted at edge %0d", k);
    check("t1_level_k", level, 1);
    step();
    check("t1_level_k1", level, 0);
    check("t1_txd_k1",   txd,   1);
    check("t1_busy_k1",  busy,  0);
    step();
    for (int c = 0; c < 10 * DIV; c++) begin
      check("t1_txd",  txd,  t1_exp[c / DIV]);
      check("t1_busy", busy, 1);
      if (c < 10 * DIV - 1) step();
    end
    step();
    check("t1_busy_end", busy, 0);
    check("t1_txd_end",  txd,  1);
    check("t1_end_edge", cyc - k, 42);
    wait_idle(200);
    exp_q = '{8'hA5};
    check_rx("t1_rx");

    // ---- burst fill 0x01..0x06 ----
    rx_q.delete(); rx_start.delete();
    for (int i = 1; i <= 6; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1; step();
      $display("[TB] burst write 0x%02h level=%0d ovf=%0d", wr_data, level, overflow);
    end
    wr_valid = 1'b0;
    check("t2_ovf",   overflow, 1);
    check("t2_level", level,    4);
    check("t2_ready", wr_ready, 0);
    wait_idle(400);
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    check_rx("t2_rx");
    for (int i = 1; i < rx_start.size(); i++)
      check("t2_gap", rx_start[i] - rx_start[i-1], 10 * DIV);

    // ---- overflow clear, then drop together with clear ----
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t3_clr", overflow, 0);
    rx_q.delete(); rx_start.delete();
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h11 + 8'(i); wr_valid = 1'b1; step();
      $display("[TB] fill write 0x%02h level=%0d ovf=%0d", wr_data, level, overflow);
    end
    check("t3_ovf_set", overflow, 1);
    wr_data = 8'h17; clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t3_set_wins", overflow, 1);
    check("t3_level",    level,    4);
    wr_valid = 1'b0; clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t3_clr2", overflow, 0);

    // ---- push while full on the pop edge ----
    wr_data = 8'h99; wr_valid = 1'b1;
    n = 0;
    while (level == 4 && n < 200) begin
      step(); n++;
    end
    wr_valid = 1'b0;
    $display("[TB] full-FIFO pop after %0d cycles, level=%0d", n, level);
    check("t4_timeout", (n < 200), 1);
    check("t4_level",   level,    3);
    check("t4_ready",   wr_ready, 1);
    check("t4_ovf",     overflow, 1);
    step();
    check("t4_start_next", txd, 0);
    wait_idle(400);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h11 + 8'(i));
    check_rx("t4_rx");

    // ---- reset mid-frame during data bit 3 ----
    rx_q.delete(); rx_start.delete();
    wr_data = 8'hC3; wr_valid = 1'b1; step(); k = cyc;
    wr_data = 8'h5A; step(); wr_valid = 1'b0;
    repeat (18) step();
    check("t5_pre_txd",   txd,   0);
    check("t5_pre_level", level, 1);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async reset mid-frame: txd=%0d level=%0d busy=%0d", txd, level, busy);
    check("t5_async_txd",   txd,   1);
    check("t5_async_level", level, 0);
    check("t5_async_busy",  busy,  0);
    repeat (2) step();
    rst = 1'b0;
    step();
    rx_q.delete(); rx_start.delete();
    wr_data = 8'h3C; wr_valid = 1'b1; step(); k = cyc; wr_valid = 1'b0;
    check("t5_level_k", level, 1);
    step();
    check("t5_txd_k1", txd, 1);
    step();
    check("t5_txd_k2",  txd,  0);
    check("t5_busy_k2", busy, 1);
    wait_idle(200);
    exp_q = '{8'h3C};
    check_rx("t5_rx");

    // ---- pointer wrap: 20 bytes, write only while ready ----
    rx_q.delete(); rx_start.delete();
    idx = 0; n = 0;
    while (idx < 20 && n < 3000) begin
      if (wr_ready) begin
        wr_data = 8'(idx); wr_valid = 1'b1;
      end else begin
        wr_valid = 1'b0;
      end
      step(); n++;
      if (wr_valid) idx++;
    end
    wr_valid = 1'b0;
    check("t6_timeout", (n < 3000), 1);
    wait_idle(400);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    check_rx("t6_rx");
    check("t6_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Byte-serial UART transmitter with a small input FIFO. It sits directly inside the chip top wrapper: the wrapper's dedicated inputs carry a byte plus a write strobe into this block. The serial line and status drive the dedicated and bidirectional outputs. Frames are 8N1, LSB first, at a fixed clocks-per-bit rate.

## Interface
Parameters:
- DIV, 434: clock cycles per serial bit; legal range 2..65535.
- DEPTH, 4: FIFO entries; a power of two, 2..16.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-high; clears all state.
- io_wr_data  in  8  byte to enqueue.
- io_wr_valid  in  1  enqueue request; qualified by io_wr_ready.
- io_wr_ready  out  1  high when the FIFO is not full.
- io_clr_ovf  in  1  synchronous clear of io_overflow.
- io_txd  out  1  serial line; idles high.
- io_busy  out  1  high while a frame is on the line (START..STOP).
- io_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- io_overflow  out  1  sticky flag; set when a write is dropped.

## Operation
- Reset values: io_txd=1, io_busy=0, io_level=0, io_overflow=0, io_wr_ready=1. The FSM is in IDLE, the FIFO is empty and the baud counter is 0.
- Push: on a clock edge where io_wr_valid=1 and io_wr_ready=1, io_wr_data is written at the tail.
- io_wr_ready depends only on the current occupancy (= level<DEPTH). A pop in the same cycle does not open a slot for a same-cycle push.
- Drop: io_wr_valid=1 with io_wr_ready=0 loses the byte and sets io_overflow on that edge.
  - io_clr_ovf=1 clears io_overflow on the next edge.
  - If a drop and io_clr_ovf occur together, the set wins.
- Pointers are clog2(DEPTH)-bit and wrap modulo DEPTH. The level counter is separate: +1 on push only, −1 on pop only, unchanged when both happen.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when level>0, pop the head into the shift register, load the baud counter with DIV−1, clear the bit index and enter START.
  - START: io_txd=0 for DIV cycles.
  - DATA: io_txd=shift[0] for DIV cycles per bit; shift right after each bit; after bit index 7 enter STOP.
  - STOP: io_txd=1 for DIV cycles.
    - At the end of STOP, if level>0, pop and go directly to START with no idle gap.
    - Otherwise go to IDLE.
- Baud counter: clog2(DIV) bits, counts down from DIV−1. The bit period ends on the cycle the counter reads 0; the counter then reloads DIV−1.
- io_txd and io_busy are registered outputs; there is no combinational path from inputs to io_txd.
- io_busy=1 in START, DATA and STOP; 0 in IDLE.
- Reset asserted mid-frame: io_txd goes to 1 immediately, with no clock needed. The frame is abandoned and the FIFO contents are discarded.

## Timing
- Write accepted at edge k into an empty FIFO with the FSM in IDLE:
  - level=1 after edge k.
  - Pop at edge k+1, where level returns to 0.
  - io_txd=0 and io_busy=1 from edge k+2.
- Frame length: exactly 10·DIV cycles from the io_txd falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately following the last stop-bit cycle.
- Throughput: sustained rate of 1 byte per 10·DIV cycles. Writes are accepted at up to 1 per cycle until the FIFO is full.
- io_wr_ready falls on the edge that makes level=DEPTH. It rises on the edge that pops a byte.

## Test plan
- Single byte: DIV=4, push 0xA5 at edge 10.
  - io_txd=0 over cycles 12–15.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop=1 over cycles 48–51, and io_busy=0 from edge 52.
- Burst fill: DEPTH=4, DIV=4, push 0x01..0x06 on consecutive cycles.
  - The first byte is popped before full, so 0x01..0x05 are accepted.
  - 0x06 is dropped and io_overflow=1.
  - Serial output decodes as 01,02,03,04,05 with no gaps between frames.
- Overflow clear: with io_overflow=1, pulse io_clr_ovf for 1 cycle → io_overflow=0.
  - Repeat with a drop in the same cycle as the clear → io_overflow stays 1.
- Push/pop same cycle: FIFO full (level=4) at the STOP→START edge with io_wr_valid=1.
  - The byte is dropped, since ready was 0.
  - level goes 4→3 and io_wr_ready=1 on the next cycle.
- Reset mid-frame: assert reset between edges during DATA bit 3.
  - io_txd=1 and io_level=0 without a clock edge.
  - After release, push 0x3C → a clean frame with the start bit 2 edges after acceptance.
- Pointer wrap: DIV=2, DEPTH=4, stream 20 bytes 0x00..0x13, keeping io_wr_valid high only while io_wr_ready=1.
  - All 20 bytes are received in order.
  - io_overflow stays 0.
